// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: registered RV32I/RV32M decode control stage.
// One instruction is decoded per handshake. The control bundle, instruction and PC
// are held in a single-entry register that feeds execute. Divide-class ops hold the
// entry invisible (BUSY) for DIV_LATENCY cycles before it is presented downstream.
module decode_ctrl_pipe #(
  parameter int DWIDTH      = 32,
  parameter bit EN_MEXT     = 1'b1,
  parameter int DIV_LATENCY = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DWIDTH-1:0] insn_i,
  input  logic [DWIDTH-1:0] pc_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DWIDTH-1:0] insn_o,
  output logic [DWIDTH-1:0] pc_o,
  output logic              pcsel_o,
  output logic              immsel_o,
  output logic              regwren_o,
  output logic              rs1sel_o,
  output logic              rs2sel_o,
  output logic              memren_o,
  output logic              memwren_o,
  output logic [1:0]        wbsel_o,
  output logic [4:0]        alusel_o,
  output logic              illegal_o
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] WBSEL_ALU = 2'd0;
  localparam logic [1:0] WBSEL_MEM = 2'd1;
  localparam logic [1:0] WBSEL_PC4 = 2'd2;
  localparam logic [1:0] WBSEL_IMM = 2'd3;

  localparam logic [4:0] ALU_OP_ADD    = 5'd0;
  localparam logic [4:0] ALU_OP_SUB    = 5'd1;
  localparam logic [4:0] ALU_OP_SLL    = 5'd2;
  localparam logic [4:0] ALU_OP_SLT    = 5'd3;
  localparam logic [4:0] ALU_OP_SLTU   = 5'd4;
  localparam logic [4:0] ALU_OP_XOR    = 5'd5;
  localparam logic [4:0] ALU_OP_SRL    = 5'd6;
  localparam logic [4:0] ALU_OP_SRA    = 5'd7;
  localparam logic [4:0] ALU_OP_OR     = 5'd8;
  localparam logic [4:0] ALU_OP_AND    = 5'd9;
  localparam logic [4:0] ALU_OP_COPY_B = 5'd10;
  localparam logic [4:0] ALU_OP_MUL    = 5'd11;
  localparam logic [4:0] ALU_OP_MULH   = 5'd12;
  localparam logic [4:0] ALU_OP_MULHSU = 5'd13;
  localparam logic [4:0] ALU_OP_MULHU  = 5'd14;
  localparam logic [4:0] ALU_OP_DIV    = 5'd15;
  localparam logic [4:0] ALU_OP_DIVU   = 5'd16;
  localparam logic [4:0] ALU_OP_REM    = 5'd17;
  localparam logic [4:0] ALU_OP_REMU   = 5'd18;

  localparam int CNT_W = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LATENCY - 1);

  typedef enum logic [1:0] {EMPTY, FULL, BUSY} state_t;

  // Base integer ALU op for a funct3; sra selects arithmetic right shift.
  function automatic logic [4:0] alu_base(input logic [2:0] f3, input logic sra);
    case (f3)
      3'd0:    alu_base = ALU_OP_ADD;
      3'd1:    alu_base = ALU_OP_SLL;
      3'd2:    alu_base = ALU_OP_SLT;
      3'd3:    alu_base = ALU_OP_SLTU;
      3'd4:    alu_base = ALU_OP_XOR;
      3'd5:    alu_base = sra ? ALU_OP_SRA : ALU_OP_SRL;
      3'd6:    alu_base = ALU_OP_OR;
      default: alu_base = ALU_OP_AND;
    endcase
  endfunction

  // RV32M op for a funct3 (MUL..REMU in encoding order).
  function automatic logic [4:0] alu_mext(input logic [2:0] f3);
    case (f3)
      3'd0:    alu_mext = ALU_OP_MUL;
      3'd1:    alu_mext = ALU_OP_MULH;
      3'd2:    alu_mext = ALU_OP_MULHSU;
      3'd3:    alu_mext = ALU_OP_MULHU;
      3'd4:    alu_mext = ALU_OP_DIV;
      3'd5:    alu_mext = ALU_OP_DIVU;
      3'd6:    alu_mext = ALU_OP_REM;
      default: alu_mext = ALU_OP_REMU;
    endcase
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       rd_nz;

  assign opcode = insn_i[6:0];
  assign funct3 = insn_i[14:12];
  assign funct7 = insn_i[31:25];
  assign rd_nz  = |insn_i[11:7];

  // ---- stage p0: combinational decode of the incoming instruction ----
  logic       pcsel_p0, immsel_p0, regwren_p0, rs1sel_p0, rs2sel_p0;
  logic       memren_p0, memwren_p0, illegal_p0, is_div_p0;
  logic [1:0] wbsel_p0;
  logic [4:0] alusel_p0;

  // Decode opcode/funct fields into the control bundle; illegal encodings zero it.
  always_comb begin
    pcsel_p0   = 1'b0;
    immsel_p0  = 1'b0;
    regwren_p0 = 1'b0;
    rs1sel_p0  = 1'b0;
    rs2sel_p0  = 1'b0;
    memren_p0  = 1'b0;
    memwren_p0 = 1'b0;
    wbsel_p0   = WBSEL_ALU;
    alusel_p0  = ALU_OP_ADD;
    illegal_p0 = 1'b0;
    is_div_p0  = 1'b0;
    case (opcode)
      OPC_LUI: begin
        immsel_p0  = 1'b1;
        wbsel_p0   = WBSEL_IMM;
        alusel_p0  = ALU_OP_COPY_B;
        regwren_p0 = rd_nz;
      end
      OPC_AUIPC: begin
        immsel_p0  = 1'b1;
        regwren_p0 = rd_nz;
      end
      OPC_JAL, OPC_JALR: begin
        pcsel_p0   = 1'b1;
        immsel_p0  = 1'b1;
        wbsel_p0   = WBSEL_PC4;
        rs1sel_p0  = (opcode == OPC_JALR);
        regwren_p0 = rd_nz;
      end
      OPC_BRANCH: begin
        pcsel_p0  = 1'b1;
        immsel_p0 = 1'b1;
        rs1sel_p0 = 1'b1;
        rs2sel_p0 = 1'b1;
      end
      OPC_LOAD: begin
        immsel_p0  = 1'b1;
        rs1sel_p0  = 1'b1;
        memren_p0  = 1'b1;
        wbsel_p0   = WBSEL_MEM;
        regwren_p0 = rd_nz;
      end
      OPC_STORE: begin
        immsel_p0  = 1'b1;
        rs1sel_p0  = 1'b1;
        rs2sel_p0  = 1'b1;
        memwren_p0 = 1'b1;
      end
      OPC_OP_IMM: begin
        immsel_p0  = 1'b1;
        rs1sel_p0  = 1'b1;
        regwren_p0 = rd_nz;
        alusel_p0  = alu_base(funct3, funct7 == 7'b0100000);
      end
      OPC_OP: begin
        rs1sel_p0  = 1'b1;
        rs2sel_p0  = 1'b1;
        regwren_p0 = rd_nz;
        if (funct7 == 7'b0000000) begin
          alusel_p0 = alu_base(funct3, 1'b0);
        end else if (funct7 == 7'b0100000 && funct3 == 3'd0) begin
          alusel_p0 = ALU_OP_SUB;
        end else if (funct7 == 7'b0100000 && funct3 == 3'd5) begin
          alusel_p0 = ALU_OP_SRA;
        end else if (funct7 == 7'b0000001 && EN_MEXT) begin
          alusel_p0 = alu_mext(funct3);
          is_div_p0 = funct3[2];
        end else begin
          illegal_p0 = 1'b1;
        end
      end
      OPC_SYSTEM: ;
      default: illegal_p0 = 1'b1;
    endcase
    if (illegal_p0) begin
      pcsel_p0   = 1'b0;
      immsel_p0  = 1'b0;
      regwren_p0 = 1'b0;
      rs1sel_p0  = 1'b0;
      rs2sel_p0  = 1'b0;
      memren_p0  = 1'b0;
      memwren_p0 = 1'b0;
      wbsel_p0   = WBSEL_ALU;
      alusel_p0  = ALU_OP_ADD;
      is_div_p0  = 1'b0;
    end
  end

  // ---- handshake and occupancy control ----
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             accept;
  logic             vld_p1;

  assign in_ready_o = !flush_i && (state == EMPTY || (state == FULL && out_ready_i));
  assign accept     = in_valid_i && in_ready_o;
  assign vld_p1     = (state == FULL);

  // Next-state logic: refill/drain in FULL, countdown in BUSY, flush overrides all.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      EMPTY, FULL: begin
        if (accept) begin
          if (is_div_p0) begin
            state_n = BUSY;
            cnt_n   = DIV_LOAD;
          end else begin
            state_n = FULL;
          end
        end else if (state == FULL && out_ready_i) begin
          state_n = EMPTY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_n = FULL;
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = EMPTY;
    endcase
    if (flush_i) begin
      state_n = EMPTY;
      cnt_n   = '0;
    end
  end

  // State and divide countdown registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // ---- stage p1: held control bundle, instruction and PC ----
  logic              pcsel_p1, immsel_p1, regwren_p1, rs1sel_p1, rs2sel_p1;
  logic              memren_p1, memwren_p1, illegal_p1;
  logic [1:0]        wbsel_p1;
  logic [4:0]        alusel_p1;
  logic [DWIDTH-1:0] insn_p1, pc_p1;

  // Capture the decoded bundle on accept; the outputs are cleared on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcsel_p1   <= 1'b0;
      immsel_p1  <= 1'b0;
      regwren_p1 <= 1'b0;
      rs1sel_p1  <= 1'b0;
      rs2sel_p1  <= 1'b0;
      memren_p1  <= 1'b0;
      memwren_p1 <= 1'b0;
      illegal_p1 <= 1'b0;
      wbsel_p1   <= WBSEL_ALU;
      alusel_p1  <= ALU_OP_ADD;
      insn_p1    <= '0;
      pc_p1      <= '0;
    end else if (accept) begin
      pcsel_p1   <= pcsel_p0;
      immsel_p1  <= immsel_p0;
      regwren_p1 <= regwren_p0;
      rs1sel_p1  <= rs1sel_p0;
      rs2sel_p1  <= rs2sel_p0;
      memren_p1  <= memren_p0;
      memwren_p1 <= memwren_p0;
      illegal_p1 <= illegal_p0;
      wbsel_p1   <= wbsel_p0;
      alusel_p1  <= alusel_p0;
      insn_p1    <= insn_i;
      pc_p1      <= pc_i;
    end
  end

  assign out_valid_o = vld_p1;
  assign insn_o      = insn_p1;
  assign pc_o        = pc_p1;
  assign pcsel_o     = pcsel_p1;
  assign immsel_o    = immsel_p1;
  assign regwren_o   = regwren_p1;
  assign rs1sel_o    = rs1sel_p1;
  assign rs2sel_o    = rs2sel_p1;
  assign memren_o    = memren_p1;
  assign memwren_o   = memwren_p1;
  assign wbsel_o     = wbsel_p1;
  assign alusel_o    = alusel_p1;
  assign illegal_o   = illegal_p1;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Testbench for decode_ctrl_pipe: directed scenarios plus a randomized run against
// an occupancy/countdown reference model and a rule-based decode model.
module tb_decode_ctrl_pipe;
  localparam int DW      = 32;
  localparam int DIV_LAT = 8;

  localparam logic [31:0] I_DIV = 32'h027342B3;
  localparam logic [31:0] I_MUL = 32'h027302B3;
  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_LW  = 32'h00012083;
  localparam logic [31:0] I_NOP = 32'h00000013;

  localparam logic [1:0] W_ALU = 2'd0, W_MEM = 2'd1, W_PC4 = 2'd2, W_IMM = 2'd3;
  localparam logic [4:0] A_ADD = 5'd0, A_SUB = 5'd1, A_SLL = 5'd2, A_SLT = 5'd3,
                         A_SLTU = 5'd4, A_XOR = 5'd5, A_SRL = 5'd6, A_SRA = 5'd7,
                         A_OR = 5'd8, A_AND = 5'd9, A_COPYB = 5'd10, A_MUL = 5'd11,
                         A_MULH = 5'd12, A_MULHSU = 5'd13, A_MULHU = 5'd14,
                         A_DIV = 5'd15, A_DIVU = 5'd16, A_REM = 5'd17, A_REMU = 5'd18;

  typedef struct packed {
    logic       pcsel, immsel, regwren, rs1sel, rs2sel, memren, memwren;
    logic [1:0] wbsel;
    logic [4:0] alusel;
    logic       illegal;
    logic       is_div;
  } bundle_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, in_valid, flush, out_ready;
  logic [DW-1:0] insn, pc;

  logic          a_in_ready, a_out_valid, a_pcsel, a_immsel, a_regwren, a_rs1sel, a_rs2sel;
  logic          a_memren, a_memwren, a_illegal;
  logic [1:0]    a_wbsel;
  logic [4:0]    a_alusel;
  logic [DW-1:0] a_insn, a_pc;

  logic          n_in_ready, n_out_valid, n_pcsel, n_immsel, n_regwren, n_rs1sel, n_rs2sel;
  logic          n_memren, n_memwren, n_illegal;
  logic [1:0]    n_wbsel;
  logic [4:0]    n_alusel;
  logic [DW-1:0] n_insn, n_pc;

  decode_ctrl_pipe #(.DWIDTH(DW), .EN_MEXT(1'b1), .DIV_LATENCY(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .in_valid_i(in_valid), .in_ready_o(a_in_ready),
    .insn_i(insn), .pc_i(pc), .flush_i(flush), .out_valid_o(a_out_valid),
    .out_ready_i(out_ready), .insn_o(a_insn), .pc_o(a_pc), .pcsel_o(a_pcsel),
    .immsel_o(a_immsel), .regwren_o(a_regwren), .rs1sel_o(a_rs1sel), .rs2sel_o(a_rs2sel),
    .memren_o(a_memren), .memwren_o(a_memwren), .wbsel_o(a_wbsel), .alusel_o(a_alusel),
    .illegal_o(a_illegal)
  );

  decode_ctrl_pipe #(.DWIDTH(DW), .EN_MEXT(1'b0), .DIV_LATENCY(DIV_LAT)) dut_nm (
    .clk(clk), .reset(reset), .in_valid_i(in_valid), .in_ready_o(n_in_ready),
    .insn_i(insn), .pc_i(pc), .flush_i(flush), .out_valid_o(n_out_valid),
    .out_ready_i(out_ready), .insn_o(n_insn), .pc_o(n_pc), .pcsel_o(n_pcsel),
    .immsel_o(n_immsel), .regwren_o(n_regwren), .rs1sel_o(n_rs1sel), .rs2sel_o(n_rs2sel),
    .memren_o(n_memren), .memwren_o(n_memwren), .wbsel_o(n_wbsel), .alusel_o(n_alusel),
    .illegal_o(n_illegal)
  );

  int checks   = 0;
  int failures = 0;

  // Control bundle derived from the instruction-set rules.
  function automatic bundle_t ref_decode(input logic [31:0] w, input bit mext);
    bundle_t    b;
    logic [4:0] base_ops [8];
    logic [4:0] m_ops [8];
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic       wr, bad;
    base_ops = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
    m_ops    = '{A_MUL, A_MULH, A_MULHSU, A_MULHU, A_DIV, A_DIVU, A_REM, A_REMU};
    opc = w[6:0];
    f3  = w[14:12];
    f7  = w[31:25];
    wr  = (w[11:7] != 5'd0);
    bad = 1'b0;
    b   = '0;
    if (opc == 7'h37) begin
      b.immsel = 1; b.wbsel = W_IMM; b.alusel = A_COPYB; b.regwren = wr;
    end else if (opc == 7'h17) begin
      b.immsel = 1; b.regwren = wr;
    end else if (opc == 7'h6F || opc == 7'h67) begin
      b.pcsel = 1; b.immsel = 1; b.wbsel = W_PC4; b.regwren = wr; b.rs1sel = (opc == 7'h67);
    end else if (opc == 7'h63) begin
      b.pcsel = 1; b.immsel = 1; b.rs1sel = 1; b.rs2sel = 1;
    end else if (opc == 7'h03) begin
      b.immsel = 1; b.rs1sel = 1; b.memren = 1; b.wbsel = W_MEM; b.regwren = wr;
    end else if (opc == 7'h23) begin
      b.immsel = 1; b.rs1sel = 1; b.rs2sel = 1; b.memwren = 1;
    end else if (opc == 7'h13) begin
      b.immsel = 1; b.rs1sel = 1; b.regwren = wr;
      b.alusel = (f3 == 3'd5 && f7 == 7'h20) ? A_SRA : base_ops[f3];
    end else if (opc == 7'h33) begin
      b.rs1sel = 1; b.rs2sel = 1; b.regwren = wr;
      if (f7 == 7'h00) b.alusel = base_ops[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) b.alusel = A_SUB;
      else if (f7 == 7'h20 && f3 == 3'd5) b.alusel = A_SRA;
      else if (f7 == 7'h01 && mext) begin
        b.alusel = m_ops[f3];
        b.is_div = (f3 >= 3'd4);
      end else bad = 1'b1;
    end else if (opc != 7'h73) begin
      bad = 1'b1;
    end
    if (bad) begin
      b = '0;
      b.illegal = 1'b1;
    end
    return b;
  endfunction

  function automatic logic [31:0] rand_insn();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 11))
      0: w[6:0] = 7'h37;  1: w[6:0] = 7'h17;  2: w[6:0] = 7'h6F;  3: w[6:0] = 7'h67;
      4: w[6:0] = 7'h63;  5: w[6:0] = 7'h03;  6: w[6:0] = 7'h23;  7: w[6:0] = 7'h13;
      8, 9: w[6:0] = 7'h33; 10: w[6:0] = 7'h73;
      default: ;
    endcase
    if (w[6:0] == 7'h33) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00; 1: w[31:25] = 7'h20; 2: w[31:25] = 7'h01;
        default: ;
      endcase
    end
    if (w[6:0] == 7'h13 && $urandom_range(0, 1) == 1) w[31:25] = 7'h20;
    if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string t, input bundle_t e, input logic [31:0] ei,
                         input logic [31:0] ep);
    chk({t, ".pcsel"},   32'(a_pcsel),   32'(e.pcsel));
    chk({t, ".immsel"},  32'(a_immsel),  32'(e.immsel));
    chk({t, ".regwren"}, 32'(a_regwren), 32'(e.regwren));
    chk({t, ".rs1sel"},  32'(a_rs1sel),  32'(e.rs1sel));
    chk({t, ".rs2sel"},  32'(a_rs2sel),  32'(e.rs2sel));
    chk({t, ".memren"},  32'(a_memren),  32'(e.memren));
    chk({t, ".memwren"}, 32'(a_memwren), 32'(e.memwren));
    chk({t, ".wbsel"},   32'(a_wbsel),   32'(e.wbsel));
    chk({t, ".alusel"},  32'(a_alusel),  32'(e.alusel));
    chk({t, ".illegal"}, 32'(a_illegal), 32'(e.illegal));
    chk({t, ".insn"},    a_insn,         ei);
    chk({t, ".pc"},      a_pc,           ep);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                       input logic r, input logic f);
    in_valid  = v;
    insn      = i;
    pc        = p;
    out_ready = r;
    flush     = f;
  endtask

  initial begin
    #2_000_000;
    $fatal(1, "FAIL watchdog simulation time limit reached");
  end

  initial begin
    bundle_t     m_b;
    logic [31:0] m_insn, m_pc, ins, p;
    logic        m_has, v, r, f, exp_rdy, exp_vld;
    int          m_wait;

    // Reset state
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick(); tick();
    reset = 1'b0;
    settle();
    chk("rst.vld", 32'(a_out_valid), 0);
    chk("rst.rdy", 32'(a_in_ready), 1);
    chk_all("rst", '0, 0, 0);
    chk("rst.nm_vld", 32'(n_out_valid), 0);

    // Reset while BUSY on a divide
    drive(1, I_DIV, 32'h100, 0, 0);
    settle();
    chk("rb.rdy_pre", 32'(a_in_ready), 1);
    tick();
    drive(0, 0, 0, 0, 0);
    settle();
    chk("rb.busy_vld", 32'(a_out_valid), 0);
    chk("rb.busy_rdy", 32'(a_in_ready), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    chk("rb.vld", 32'(a_out_valid), 0);
    chk("rb.rdy", 32'(a_in_ready), 1);
    chk_all("rb", '0, 0, 0);

    // Back-to-back add then lw
    drive(1, I_ADD, 32'h200, 1, 0);
    tick();
    drive(1, I_LW, 32'h204, 1, 0);
    settle();
    chk("b2b.add_vld", 32'(a_out_valid), 1);
    chk("b2b.add_rdy", 32'(a_in_ready), 1);
    chk("b2b.add_alu", 32'(a_alusel), 32'(A_ADD));
    chk("b2b.add_wren", 32'(a_regwren), 1);
    chk("b2b.add_wb", 32'(a_wbsel), 32'(W_ALU));
    chk_all("b2b.add", ref_decode(I_ADD, 1), I_ADD, 32'h200);
    tick();
    drive(0, 0, 0, 1, 0);
    settle();
    chk("b2b.lw_vld", 32'(a_out_valid), 1);
    chk("b2b.lw_memren", 32'(a_memren), 1);
    chk("b2b.lw_wb", 32'(a_wbsel), 32'(W_MEM));
    chk_all("b2b.lw", ref_decode(I_LW, 1), I_LW, 32'h204);
    tick();
    settle();
    chk("b2b.drain_vld", 32'(a_out_valid), 0);

    // Divide latency, then multiply latency
    drive(1, I_DIV, 32'h300, 1, 0);
    tick();
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < DIV_LAT; i++) begin
      settle();
      chk("div.busy_vld", 32'(a_out_valid), 0);
      chk("div.busy_rdy", 32'(a_in_ready), 0);
      tick();
    end
    settle();
    chk("div.vld", 32'(a_out_valid), 1);
    chk("div.alu", 32'(a_alusel), 32'(A_DIV));
    chk_all("div", ref_decode(I_DIV, 1), I_DIV, 32'h300);
    tick();
    drive(1, I_MUL, 32'h400, 1, 0);
    tick();
    drive(0, 0, 0, 1, 0);
    settle();
    chk("mul.vld", 32'(a_out_valid), 1);
    chk("mul.alu", 32'(a_alusel), 32'(A_MUL));
    tick();

    // M extension disabled: multiply is illegal but still delivered
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1, I_MUL, 32'h500, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    settle();
    chk("nm.vld", 32'(n_out_valid), 1);
    chk("nm.illegal", 32'(n_illegal), 1);
    chk("nm.wren", 32'(n_regwren), 0);
    chk("nm.pcsel", 32'(n_pcsel), 0);
    chk("nm.memren", 32'(n_memren), 0);
    chk("nm.memwren", 32'(n_memwren), 0);
    chk("nm.insn", n_insn, I_MUL);
    chk_all("nm.mext_on", ref_decode(I_MUL, 1), I_MUL, 32'h500);
    drive(0, 0, 0, 1, 0);
    tick();

    // nop: rd = x0 suppresses the write
    drive(1, I_NOP, 32'h600, 1, 0);
    tick();
    drive(0, 0, 0, 1, 0);
    settle();
    chk("nop.vld", 32'(a_out_valid), 1);
    chk("nop.wren", 32'(a_regwren), 0);
    chk("nop.alu", 32'(a_alusel), 32'(A_ADD));
    chk("nop.illegal", 32'(a_illegal), 0);
    tick();

    // Backpressure hold, then flush with a valid incoming instruction
    drive(1, I_ADD, 32'h700, 0, 0);
    tick();
    drive(1, I_LW, 32'h704, 0, 0);
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("bp.vld", 32'(a_out_valid), 1);
      chk("bp.rdy", 32'(a_in_ready), 0);
      chk_all("bp.hold", ref_decode(I_ADD, 1), I_ADD, 32'h700);
      tick();
    end
    drive(1, I_LW, 32'h704, 0, 1);
    settle();
    chk("fl.rdy", 32'(a_in_ready), 0);
    tick();
    drive(0, 0, 0, 0, 0);
    settle();
    chk("fl.vld", 32'(a_out_valid), 0);
    chk("fl.rdy_after", 32'(a_in_ready), 1);
    chk("fl.insn_kept", a_insn, I_ADD);
    chk("fl.pc_kept", a_pc, 32'h700);

    // Flush during BUSY, then a normal accept
    drive(1, I_DIV, 32'h800, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0);
    settle();
    chk("flb.vld", 32'(a_out_valid), 0);
    chk("flb.rdy", 32'(a_in_ready), 1);
    drive(1, I_ADD, 32'h804, 1, 0);
    tick();
    drive(0, 0, 0, 1, 0);
    settle();
    chk("flb.add_vld", 32'(a_out_valid), 1);
    chk("flb.add_insn", a_insn, I_ADD);
    tick();

    // Randomized traffic against the occupancy/countdown model
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_has  = 1'b0;
    m_wait = 0;
    m_b    = '0;
    m_insn = '0;
    m_pc   = '0;
    for (int n = 0; n < 600; n++) begin
      v   = ($urandom_range(0, 9) < 6);
      r   = ($urandom_range(0, 9) < 6);
      f   = ($urandom_range(0, 24) == 0);
      ins = rand_insn();
      p   = $urandom;
      drive(v, ins, p, r, f);
      settle();
      exp_vld = m_has && (m_wait == 0);
      exp_rdy = !f && (!m_has || (exp_vld && r));
      chk("rnd.rdy", 32'(a_in_ready), 32'(exp_rdy));
      chk("rnd.vld", 32'(a_out_valid), 32'(exp_vld));
      if (exp_vld) chk_all("rnd", m_b, m_insn, m_pc);
      if (f) begin
        m_has = 1'b0;
      end else if (v && exp_rdy) begin
        m_has  = 1'b1;
        m_b    = ref_decode(ins, 1);
        m_insn = ins;
        m_pc   = p;
        m_wait = m_b.is_div ? DIV_LAT : 0;
      end else if (exp_vld && r) begin
        m_has = 1'b0;
      end else if (m_has && m_wait > 0) begin
        m_wait--;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
